// File: rtl/apb_uart_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : apb_uart_master_arbiter
// Brief   : Round-robin APB master that shares one APB UART slave between two
//           requesters. Optional ACCESS wait-state timeout: APB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module apb_uart_master_arbiter #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 8,
  parameter int RDATA_W        = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               req0_valid,
  input  logic               req0_write,
  input  logic [ADDR_W-1:0]  req0_addr,
  input  logic [DATA_W-1:0]  req0_wdata,
  output logic               req0_ack,
  output logic [RDATA_W-1:0] req0_rdata,
  output logic               req0_err,
  input  logic               req1_valid,
  input  logic               req1_write,
  input  logic [ADDR_W-1:0]  req1_addr,
  input  logic [DATA_W-1:0]  req1_wdata,
  output logic               req1_ack,
  output logic [RDATA_W-1:0] req1_rdata,
  output logic               req1_err,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [ADDR_W-1:0]  PADDR,
  output logic [DATA_W-1:0]  PWDATA,
  input  logic [RDATA_W-1:0] PRDATA,
  input  logic               PREADY,
  output logic [1:0]         grant,
  output logic               busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]         r_state;
  logic               r_last;
  logic               r_pwrite;
  logic [ADDR_W-1:0]  r_paddr;
  logic [DATA_W-1:0]  r_pwdata;
  logic               r_ack0;
  logic               r_ack1;
  logic [RDATA_W-1:0] r_rdata0;
  logic [RDATA_W-1:0] r_rdata1;

  logic               w_elig0;
  logic               w_elig1;
  logic               w_win;
  logic               w_pick1;
  logic               w_done;
  logic               w_tmo;
  logic               w_end;

  // A requester being acked this cycle is still holding valid; it must not be regranted.
  assign w_elig0 = req0_valid & ~r_ack0;
  assign w_elig1 = req1_valid & ~r_ack1;
  assign w_win   = w_elig0 | w_elig1;
  assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last);
  assign w_done  = (r_state == S_ACCESS) & PREADY;
  assign w_end   = w_done | w_tmo;

`ifdef APB_TIMEOUT_EN
  localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [C_CNT_W-1:0] r_cnt;
  logic               r_err0;
  logic               r_err1;
  logic               w_cnt_max;

  assign w_cnt_max = (r_cnt == C_CNT_W'(TIMEOUT_CYCLES));
  assign w_tmo     = (r_state == S_ACCESS) & ~PREADY & w_cnt_max;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt  <= '0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      if (r_state == S_SETUP) begin
        r_cnt <= '0;
      end else if ((r_state == S_ACCESS) && !PREADY && !w_cnt_max) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_err0 <= w_tmo & ~r_last;
      r_err1 <= w_tmo &  r_last;
    end
  end

  assign req0_err = r_err0;
  assign req1_err = r_err1;
`else
  logic w_unused_tmo;

  assign w_tmo        = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign req0_err     = 1'b0;
  assign req1_err     = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_ack0 <= w_end & ~r_last;
      r_ack1 <= w_end &  r_last;
      case (r_state)
        S_IDLE: begin
          if (w_win) begin
            r_state  <= S_SETUP;
            r_last   <= w_pick1;
            r_pwrite <= w_pick1 ? req1_write : req0_write;
            r_paddr  <= w_pick1 ? req1_addr  : req0_addr;
            r_pwdata <= w_pick1 ? req1_wdata : req0_wdata;
          end
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_done && !r_pwrite) begin
            if (r_last) begin
              r_rdata1 <= PRDATA;
            end else begin
              r_rdata0 <= PRDATA;
            end
          end
          if (w_end) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The owner during a transfer is always the most recent winner.
  assign PSEL       = (r_state != S_IDLE);
  assign PENABLE    = (r_state == S_ACCESS);
  assign busy       = PSEL;
  assign grant      = PSEL ? (r_last ? 2'b10 : 2'b01) : 2'b00;
  assign PWRITE     = r_pwrite;
  assign PADDR      = r_paddr;
  assign PWDATA     = r_pwdata;
  assign req0_ack   = r_ack0;
  assign req1_ack   = r_ack1;
  assign req0_rdata = r_rdata0;
  assign req1_rdata = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_uart_master_arbiter
// Brief   : Directed self-checking bench for apb_uart_master_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_apb_uart_master_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req0_valid, req0_write, req0_ack, req0_err;
  logic [11:0] req0_addr;
  logic [7:0]  req0_wdata;
  logic [31:0] req0_rdata;
  logic        req1_valid, req1_write, req1_ack, req1_err;
  logic [11:0] req1_addr;
  logic [7:0]  req1_wdata;
  logic [31:0] req1_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, busy;
  logic [11:0] PADDR;
  logic [7:0]  PWDATA;
  logic [31:0] PRDATA;
  logic [1:0]  grant;

  int n_pass  = 0;
  int n_total = 0;

  apb_uart_master_arbiter #(
    .ADDR_W(12), .DATA_W(8), .RDATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_rdata(req0_rdata),
    .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_rdata(req1_rdata),
    .req1_err(req1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .grant(grant), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    PRESETn = 1'b0;
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    PREADY = 1'b1; PRDATA = '0;

    // Reset values
    #3;
    chk("rst_psel", 32'(PSEL), 0);
    chk("rst_penable", 32'(PENABLE), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_paddr", 32'(PADDR), 0);
    chk("rst_pwdata", 32'(PWDATA), 0);
    chk("rst_pwrite", 32'(PWRITE), 0);
    chk("rst_acks", 32'({req0_ack, req1_ack, req0_err, req1_err}), 0);
    chk("rst_rdata0", req0_rdata, 0);
    chk("rst_rdata1", req1_rdata, 0);
    #10 PRESETn = 1'b1;
    tick();

    // Single write from req0
    req0_valid = 1; req0_write = 1; req0_addr = 12'h104; req0_wdata = 8'hA5; PREADY = 1;
    tick();
    chk("wr_setup_psel", 32'(PSEL), 1);
    chk("wr_setup_penable", 32'(PENABLE), 0);
    chk("wr_setup_paddr", 32'(PADDR), 32'h104);
    chk("wr_setup_pwdata", 32'(PWDATA), 32'hA5);
    chk("wr_setup_pwrite", 32'(PWRITE), 1);
    chk("wr_setup_grant", 32'(grant), 32'b01);
    chk("wr_setup_busy", 32'(busy), 1);
    tick();
    chk("wr_access_psel", 32'(PSEL), 1);
    chk("wr_access_penable", 32'(PENABLE), 1);
    chk("wr_access_ack", 32'(req0_ack), 0);
    tick();
    chk("wr_ack", 32'(req0_ack), 1);
    chk("wr_err", 32'(req0_err), 0);
    chk("wr_ack_psel", 32'(PSEL), 0);
    chk("wr_ack_grant", 32'(grant), 0);
    chk("wr_ack_busy", 32'(busy), 0);
    chk("wr_rdata0", req0_rdata, 0);
    chk("wr_idle_paddr_hold", 32'(PADDR), 32'h104);
    req0_valid = 0;
    tick();
    chk("wr_ack_pulse", 32'(req0_ack), 0);
    chk("wr_no_regrant", 32'(PSEL), 0);

    // Read from req1 with three wait states
    req1_valid = 1; req1_write = 0; req1_addr = 12'h108; req1_wdata = 8'h00; PREADY = 0;
    tick();
    chk("rd_setup_grant", 32'(grant), 32'b10);
    chk("rd_setup_paddr", 32'(PADDR), 32'h108);
    chk("rd_setup_pwrite", 32'(PWRITE), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_apb", 32'({PSEL, PENABLE, PWRITE, PADDR}), {18'd0, 1'b1, 1'b1, 1'b0, 12'h108});
      chk("rd_wait_grant", 32'(grant), 32'b10);
      chk("rd_wait_ack", 32'(req1_ack), 0);
      tick();
    end
    chk("rd_last_access", 32'({PSEL, PENABLE}), 32'b11);
    PREADY = 1; PRDATA = 32'h0000_005A;
    tick();
    chk("rd_ack", 32'(req1_ack), 1);
    chk("rd_err", 32'(req1_err), 0);
    chk("rd_rdata1", req1_rdata, 32'h5A);
    chk("rd_rdata0_untouched", req0_rdata, 0);
    chk("rd_ack_psel", 32'(PSEL), 0);
    req1_valid = 0; PRDATA = 32'h0;
    tick();

    // Tie with last=1: req0 first, req1 granted in req0's ack cycle
    req0_valid = 1; req0_write = 1; req0_addr = 12'h110; req0_wdata = 8'h11;
    req1_valid = 1; req1_write = 1; req1_addr = 12'h120; req1_wdata = 8'h22;
    tick();
    chk("tie1_grant", 32'(grant), 32'b01);
    chk("tie1_paddr", 32'(PADDR), 32'h110);
    tick();
    tick();
    chk("tie1_ack0", 32'(req0_ack), 1);
    chk("tie1_ack_grant", 32'(grant), 0);
    req0_valid = 0;
    tick();
    chk("tie1_nobubble_grant", 32'(grant), 32'b10);
    chk("tie1_nobubble_paddr", 32'(PADDR), 32'h120);
    chk("tie1_nobubble_pwdata", 32'(PWDATA), 32'h22);
    tick();
    tick();
    chk("tie1_ack1", 32'(req1_ack), 1);
    req1_valid = 0;
    tick();

    // Held valid: no regrant in the ack cycle, regrant the cycle after
    req0_valid = 1; req0_write = 1; req0_addr = 12'h130; req0_wdata = 8'h33;
    tick();
    chk("hold_grant", 32'(grant), 32'b01);
    tick();
    tick();
    chk("hold_ack", 32'(req0_ack), 1);
    tick();
    chk("hold_ack_cycle_nogrant", 32'({PSEL, grant}), 0);
    chk("hold_ack_done", 32'(req0_ack), 0);
    tick();
    chk("hold_regrant", 32'(grant), 32'b01);
    tick();
    tick();
    chk("hold_ack2", 32'(req0_ack), 1);
    req0_valid = 0;
    tick();

    // Tie with last=0: req1 wins, then req0 in req1's ack cycle
    req0_valid = 1; req0_write = 1; req0_addr = 12'h140; req0_wdata = 8'h44;
    req1_valid = 1; req1_write = 1; req1_addr = 12'h150; req1_wdata = 8'h55;
    tick();
    chk("tie2_grant", 32'(grant), 32'b10);
    chk("tie2_paddr", 32'(PADDR), 32'h150);
    tick();
    tick();
    chk("tie2_ack1", 32'(req1_ack), 1);
    req1_valid = 0;
    tick();
    chk("tie2_alt_grant", 32'(grant), 32'b01);
    chk("tie2_alt_paddr", 32'(PADDR), 32'h140);
    tick();
    tick();
    chk("tie2_ack0", 32'(req0_ack), 1);
    req0_valid = 0;
    tick();

    // Reset during ACCESS (last=0 before reset)
    req0_valid = 1; req0_write = 1; req0_addr = 12'h160; req0_wdata = 8'h66; PREADY = 0;
    tick();
    tick();
    chk("rstacc_penable", 32'(PENABLE), 1);
    #2 PRESETn = 0;
    #1;
    chk("rstacc_drop", 32'({PSEL, PENABLE, busy, grant}), 0);
    req0_valid = 0;
    tick();
    #2 PRESETn = 1;
    tick();
    chk("rstacc_no_ack", 32'({req0_ack, req1_ack}), 0);
    chk("rstacc_idle", 32'(PSEL), 0);
    PREADY = 1;
    req0_valid = 1; req0_write = 1; req0_addr = 12'h161; req0_wdata = 8'h67;
    req1_valid = 1; req1_write = 1; req1_addr = 12'h162; req1_wdata = 8'h68;
    tick();
    chk("rstacc_ptr_reset", 32'(grant), 32'b01);
    tick();
    tick();
    chk("rstacc_ack0", 32'(req0_ack), 1);
    req0_valid = 0;
    tick();
    tick();
    tick();
    chk("rstacc_ack1", 32'(req1_ack), 1);
    req1_valid = 0;
    tick();

    // Stalled slave: timeout when enabled, indefinite wait otherwise
    req0_valid = 1; req0_write = 0; req0_addr = 12'h170; PREADY = 0; PRDATA = 32'hDEAD_BEEF;
    tick();
    tick();
`ifdef APB_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (!req0_ack && n < 40) begin
        tick();
        n++;
      end
      chk("tmo_latency", 32'(n), 17);
      chk("tmo_ack", 32'(req0_ack), 1);
      chk("tmo_err", 32'(req0_err), 1);
      chk("tmo_psel", 32'({PSEL, PENABLE}), 0);
      chk("tmo_rdata", req0_rdata, 0);
      req0_valid = 0;
      tick();
    end
`else
    for (int i = 0; i < 40; i++) tick();
    chk("stall_psel", 32'({PSEL, PENABLE}), 32'b11);
    chk("stall_no_ack", 32'({req0_ack, req0_err}), 0);
    PREADY = 1;
    tick();
    chk("stall_ack", 32'(req0_ack), 1);
    chk("stall_err", 32'(req0_err), 0);
    chk("stall_rdata", req0_rdata, 32'hDEAD_BEEF);
    req0_valid = 0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
